// File: rtl/multi_radix_hex_pkg.sv
// Shared constants and helpers for the radix/loser-tree index multiplier.
package multi_radix_hex_pkg;

  localparam int MUL_MIN_STAGE = 2;
  localparam int MUL_MAX_STAGE = 8;

  // Output narrowing policy encodings.
  localparam int MUL_WRAP = 0;
  localparam int MUL_SAT  = 1;

  // Each operand gains one extension bit, so the signed product is exact for any sign mix.
  function automatic int prod_width(input int a, input int b);
    return a + b + 2;
  endfunction

endpackage

// File: rtl/multi_radix_hex_loser_mul_narrow.sv
// Combinational narrowing of the exact product to the result width, with loss detection.
module multi_radix_hex_loser_mul_narrow
  import multi_radix_hex_pkg::*;
#(
  parameter int PW         = 31,
  parameter int W          = 15,
  parameter bit RES_SIGNED = 1'b1,
  parameter int SAT_MODE   = MUL_WRAP
) (
  input  logic signed [PW-1:0] prod_i,
  output logic [W-1:0]         res_o,
  output logic                 ovf_o
);

  logic         neg;
  logic [W-1:0] lo_lim, hi_lim;

  always_comb begin
    neg    = prod_i[PW-1];
    lo_lim = '0;
    hi_lim = '1;
    ovf_o  = 1'b0;
    // In range iff every bit above the kept field matches the field's sign (or is zero).
    if (RES_SIGNED) begin
      lo_lim[W-1] = 1'b1;
      hi_lim[W-1] = 1'b0;
      ovf_o       = (prod_i[PW-1:W-1] != {(PW-W+1){neg}});
    end else begin
      ovf_o       = (prod_i[PW-1:W] != '0);
    end
    res_o = prod_i[W-1:0];
    if (SAT_MODE == MUL_SAT && ovf_o) res_o = neg ? lo_lim : hi_lim;
  end

endmodule

// File: rtl/multi_radix_hex_loser_mul_pipe.sv
// Pipelined signed/unsigned multiplier with valid chain, clock enable and wrap/saturate narrowing.
module multi_radix_hex_loser_mul_pipe
  import multi_radix_hex_pkg::*;
#(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 4,
  parameter int din0_WIDTH  = 15,
  parameter int din1_WIDTH  = 14,
  parameter int dout_WIDTH  = 15,
  parameter int DIN0_SIGNED = 1,
  parameter int DIN1_SIGNED = 0,
  parameter int SAT_MODE    = MUL_WRAP
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  din_valid,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  dout_valid,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  dout_ovf
);

  localparam int PW         = prod_width(din0_WIDTH, din1_WIDTH);
  localparam bit RES_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);
  // Narrowed-result stage is stage 2 when NUM_STAGE=2, else stage 3; NDLY delay stages follow.
  localparam int NDLY       = (NUM_STAGE > MUL_MIN_STAGE) ? NUM_STAGE - 3 : 0;

  logic [NUM_STAGE:1]         vld_pipe;
  logic [din0_WIDTH-1:0]      a_q;
  logic [din1_WIDTH-1:0]      b_q;
  logic signed [din0_WIDTH:0] a_ext;
  logic signed [din1_WIDTH:0] b_ext;
  logic signed [PW-1:0]       prod_d, prod_src;
  logic [dout_WIDTH-1:0]      res_d;
  logic                       ovf_d;
  logic [dout_WIDTH-1:0]      res_q [0:NDLY];
  logic                       ovf_q [0:NDLY];
  logic [31:0]                unused_id;

  assign unused_id = 32'(ID);

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else if (ce) begin
      vld_pipe <= {vld_pipe[NUM_STAGE-1:1], din_valid};
      a_q      <= din0;
      b_q      <= din1;
    end
  end

  assign a_ext  = {((DIN0_SIGNED != 0) & a_q[din0_WIDTH-1]), a_q};
  assign b_ext  = {((DIN1_SIGNED != 0) & b_q[din1_WIDTH-1]), b_q};
  assign prod_d = PW'(a_ext) * PW'(b_ext);

  if (NUM_STAGE > MUL_MIN_STAGE) begin : g_prod_reg
    logic signed [PW-1:0] prod_q;
    always_ff @(posedge clk) begin
      if (reset)   prod_q <= '0;
      else if (ce) prod_q <= prod_d;
    end
    assign prod_src = prod_q;
  end else begin : g_prod_comb
    assign prod_src = prod_d;
  end

  multi_radix_hex_loser_mul_narrow #(
    .PW         (PW),
    .W          (dout_WIDTH),
    .RES_SIGNED (RES_SIGNED),
    .SAT_MODE   (SAT_MODE)
  ) u_narrow (
    .prod_i (prod_src),
    .res_o  (res_d),
    .ovf_o  (ovf_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q[0] <= '0;
      ovf_q[0] <= 1'b0;
    end else if (ce) begin
      res_q[0] <= res_d;
      ovf_q[0] <= ovf_d;
    end
  end

  for (genvar i = 1; i <= NDLY; i++) begin : g_dly
    always_ff @(posedge clk) begin
      if (reset) begin
        res_q[i] <= '0;
        ovf_q[i] <= 1'b0;
      end else if (ce) begin
        res_q[i] <= res_q[i-1];
        ovf_q[i] <= ovf_q[i-1];
      end
    end
  end

  assign dout_valid = vld_pipe[NUM_STAGE];
  assign dout       = res_q[NDLY];
  assign dout_ovf   = ovf_q[NDLY];

endmodule

// File: tb/tb_multi_radix_hex_loser_mul_pipe.sv
// Randomised bench: several multiplier configurations share one stimulus stream and one history model.
module tb_multi_radix_hex_loser_mul_pipe;

  localparam int N = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        din_valid = 1'b0;
  logic [14:0] din0 = '0;
  logic [13:0] din1 = '0;

  always #5 clk = ~clk;

  // Per-instance configuration: latency, result width, signedness, saturate.
  int cL   [N] = '{4, 4, 2, 8, 4, 3};
  int cW   [N] = '{15, 15, 15, 15, 29, 10};
  bit cS0  [N] = '{1, 1, 1, 1, 0, 1};
  bit cS1  [N] = '{0, 0, 0, 0, 0, 1};
  bit cSat [N] = '{0, 1, 0, 0, 0, 1};

  logic        v [N];
  logic        o [N];
  logic [31:0] d [N];
  logic [14:0] q0, q1, q2, q3;
  logic [28:0] q4;
  logic [9:0]  q5;

  assign d[0] = 32'(q0);
  assign d[1] = 32'(q1);
  assign d[2] = 32'(q2);
  assign d[3] = 32'(q3);
  assign d[4] = 32'(q4);
  assign d[5] = 32'(q5);

  multi_radix_hex_loser_mul_pipe #(.ID(0), .NUM_STAGE(4)) u0 (
    .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
    .dout_valid(v[0]), .dout(q0), .dout_ovf(o[0]));
  multi_radix_hex_loser_mul_pipe #(.ID(1), .NUM_STAGE(4), .SAT_MODE(1)) u1 (
    .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
    .dout_valid(v[1]), .dout(q1), .dout_ovf(o[1]));
  multi_radix_hex_loser_mul_pipe #(.ID(2), .NUM_STAGE(2)) u2 (
    .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
    .dout_valid(v[2]), .dout(q2), .dout_ovf(o[2]));
  multi_radix_hex_loser_mul_pipe #(.ID(3), .NUM_STAGE(8)) u3 (
    .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
    .dout_valid(v[3]), .dout(q3), .dout_ovf(o[3]));
  multi_radix_hex_loser_mul_pipe #(.ID(4), .NUM_STAGE(4), .dout_WIDTH(29),
    .DIN0_SIGNED(0), .DIN1_SIGNED(0)) u4 (
    .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
    .dout_valid(v[4]), .dout(q4), .dout_ovf(o[4]));
  multi_radix_hex_loser_mul_pipe #(.ID(5), .NUM_STAGE(3), .dout_WIDTH(10),
    .DIN0_SIGNED(1), .DIN1_SIGNED(1), .SAT_MODE(1)) u5 (
    .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
    .dout_valid(v[5]), .dout(q5), .dout_ovf(o[5]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Exact product by plain integer arithmetic, then range check and wrap/clamp.
  function automatic void model(input logic [14:0] a, input logic [13:0] b, input int i,
                                output logic [31:0] res, output logic ovf);
    longint av, bv, p, lo, hi;
    av = cS0[i] ? longint'($signed(a)) : longint'(a);
    bv = cS1[i] ? longint'($signed(b)) : longint'(b);
    p  = av * bv;
    if (cS0[i] || cS1[i]) begin
      hi = (longint'(1) << (cW[i] - 1)) - 1;
      lo = -(hi + 1);
    end else begin
      hi = (longint'(1) << cW[i]) - 1;
      lo = 0;
    end
    ovf = (p < lo) || (p > hi);
    if (cSat[i] && ovf) p = (p < lo) ? lo : hi;
    res = 32'(p & ((longint'(1) << cW[i]) - 1));
  endfunction

  // History of every enabled-edge sample since the last reset.
  typedef struct {
    bit          v;
    logic [14:0] a;
    logic [13:0] b;
  } ent_t;

  ent_t hist[$];
  bit   started  = 1'b0;
  bit   rst_edge = 1'b0;
  bit   hold_edge = 1'b0;

  always @(posedge clk) begin
    rst_edge  = 1'b0;
    hold_edge = 1'b0;
    if (reset) begin
      hist.delete();
      started  = 1'b1;
      rst_edge = 1'b1;
    end else if (ce) begin
      hist.push_back('{din_valid, din0, din1});
    end else begin
      hold_edge = 1'b1;
    end
  end

  logic [31:0] pd [N];
  logic        po [N];

  always @(negedge clk) begin
    int          n;
    bit          ev;
    logic [31:0] ed;
    logic        eo;
    if (started) begin
      n = hist.size();
      for (int i = 0; i < N; i++) begin
        ev = 1'b0;
        if (n >= cL[i]) ev = hist[n - cL[i]].v;
        chk($sformatf("valid[%0d]", i), 32'(v[i]), 32'(ev));
        if (ev) begin
          model(hist[n - cL[i]].a, hist[n - cL[i]].b, i, ed, eo);
          chk($sformatf("dout[%0d]", i), d[i], ed);
          chk($sformatf("ovf[%0d]", i), 32'(o[i]), 32'(eo));
        end
        if (rst_edge) begin
          chk($sformatf("rst_dout[%0d]", i), d[i], 32'd0);
          chk($sformatf("rst_ovf[%0d]", i), 32'(o[i]), 32'd0);
        end
        if (hold_edge) begin
          chk($sformatf("hold_dout[%0d]", i), d[i], pd[i]);
          chk($sformatf("hold_ovf[%0d]", i), 32'(o[i]), 32'(po[i]));
        end
        pd[i] = d[i];
        po[i] = o[i];
      end
    end
  end

  task automatic issue(input logic [14:0] a, input logic [13:0] b);
    din0 = a;
    din1 = b;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  function automatic logic [14:0] pick_a();
    case ($urandom_range(0, 5))
      0: return 15'h0000;
      1: return 15'h7FFF;
      2: return 15'h4000;
      3: return 15'h3FFF;
      4: return 15'h0001;
      default: return 15'($urandom);
    endcase
  endfunction

  function automatic logic [13:0] pick_b();
    case ($urandom_range(0, 5))
      0: return 14'h0000;
      1: return 14'h3FFF;
      2: return 14'h2000;
      3: return 14'h1FFF;
      4: return 14'h0002;
      default: return 14'($urandom);
    endcase
  endfunction

  initial begin
    logic [31:0] md;
    logic        mo;

    // Hand-computed anchors for the model.
    model(15'h7FFD, 14'd5, 0, md, mo);
    chk("pin_neg15", md, 32'h7FF1);    chk("pin_neg15_ovf", 32'(mo), 32'd0);
    model(15'd16383, 14'd16383, 0, md, mo);
    chk("pin_wrap", md, 32'h0001);     chk("pin_wrap_ovf", 32'(mo), 32'd1);
    model(15'd16383, 14'd16383, 1, md, mo);
    chk("pin_sat", md, 32'h3FFF);      chk("pin_sat_ovf", 32'(mo), 32'd1);
    model(15'h4000, 14'd2, 1, md, mo);
    chk("pin_nsat", md, 32'h4000);     chk("pin_nsat_ovf", 32'(mo), 32'd1);
    model(15'h7FFF, 14'h3FFF, 4, md, mo);
    chk("pin_uns", md, 32'h1FFF4001);  chk("pin_uns_ovf", 32'(mo), 32'd0);

    reset = 1'b1;
    ce    = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Single pulse: latency in enabled edges for 4, 2 and 8 stage pipes.
    din0 = 15'h7FFD;
    din1 = 14'd5;
    din_valid = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      din_valid = 1'b0;
      chk($sformatf("lat4_k%0d", k), 32'(v[0]), 32'(k == 4));
      chk($sformatf("lat2_k%0d", k), 32'(v[2]), 32'(k == 2));
      chk($sformatf("lat8_k%0d", k), 32'(v[3]), 32'(k == 8));
      if (k == 4) chk("lat4_dout", d[0], 32'h7FF1);
    end

    issue(15'd16383, 14'd16383);
    repeat (3) @(negedge clk);
    chk("wrap_dout", d[0], 32'h0001);
    chk("wrap_ovf", 32'(o[0]), 32'd1);
    chk("sat_dout", d[1], 32'h3FFF);

    issue(15'h4000, 14'd2);
    repeat (3) @(negedge clk);
    chk("nsat_dout", d[1], 32'h4000);
    chk("nsat_ovf", 32'(o[1]), 32'd1);

    issue(15'h7FFF, 14'h3FFF);
    repeat (3) @(negedge clk);
    chk("uns_dout", d[4], 32'h1FFF4001);
    chk("uns_ovf", 32'(o[4]), 32'd0);

    // Back-to-back squares then a mid-flight stall.
    for (int k = 1; k <= 3; k++) begin
      din0 = 15'(k);
      din1 = 14'(k);
      din_valid = 1'b1;
      @(negedge clk);
    end
    din_valid = 1'b0;
    @(negedge clk);
    ce = 1'b0;
    repeat (5) @(negedge clk);
    ce = 1'b1;
    repeat (10) @(negedge clk);

    // Reset with results in flight, then reset while ce is low.
    for (int k = 1; k <= 3; k++) begin
      din0 = 15'(k + 4);
      din1 = 14'(k + 7);
      din_valid = 1'b1;
      @(negedge clk);
    end
    din_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    issue(15'd9, 14'd9);
    issue(15'd10, 14'd10);
    ce = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ce = 1'b1;
    repeat (10) @(negedge clk);

    // Randomised traffic with enable gaps and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      ce        = ($urandom_range(0, 9) != 0);
      din_valid = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 299) == 0);
      din0      = pick_a();
      din1      = pick_b();
      @(negedge clk);
    end
    reset = 1'b0;
    ce = 1'b1;
    din_valid = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_radix_hex_loser_mul_pipe.md
Name: multi_radix_hex_loser_mul_pipe

Overview:
- Parametrised pipelined multiplier with valid tracking. Replaces the fixed-width, fixed-depth DSP48 multipliers used in the radix/loser-tree datapath (index and offset arithmetic).
- Adds per-operand signedness, configurable pipeline depth, a valid pipeline, and wrap or saturate output narrowing with an overflow flag.
- Fully pipelined: accepts one operand pair per enabled cycle.

Parameters:
- ID, 1, instance identifier; no functional effect.
- NUM_STAGE, 4, total latency in enabled cycles; legal range 2..8.
- din0_WIDTH, 15, width of operand A.
- din1_WIDTH, 14, width of operand B.
- dout_WIDTH, 15, result width; legal range 1..din0_WIDTH+din1_WIDTH.
- DIN0_SIGNED, 1, A is two's complement when 1, unsigned when 0.
- DIN1_SIGNED, 0, B is two's complement when 1, unsigned when 0.
- SAT_MODE, 0, 0 = wrap (keep low dout_WIDTH bits); 1 = saturate to the result range.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  global clock enable; low freezes every register.
- din_valid  in  1  operand pair valid, sampled when ce=1.
- din0  in  din0_WIDTH  operand A.
- din1  in  din1_WIDTH  operand B.
- dout_valid  out  1  result valid.
- dout  out  dout_WIDTH  product.
- dout_ovf  out  1  narrowing lost information for this result.

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on port reset; it takes priority over ce.
- Reset values: dout_valid=0, dout=0, dout_ovf=0. All internal data and valid registers clear to 0.
- Stage structure:
  - Stage 1 registers din0, din1 and din_valid.
  - Stage 2 registers the full product.
  - Stage 3 registers the narrowed result and ovf.
  - The remaining NUM_STAGE-3 stages are pure delay.
  - When NUM_STAGE=2, multiply and narrowing are combinational in stage 2.
- Latency: a pair sampled on cycle N with ce=1 appears at dout/dout_valid after exactly NUM_STAGE further ce=1 edges. Cycles with ce=0 do not count.
- ce=0: no register changes, including valid bits. Outputs hold their values.
- Data registers load unconditionally when ce=1. Validity is carried only by the valid chain.
- The bench checks dout/dout_ovf only when dout_valid=1.
- Throughput: one result per ce=1 cycle. Back-to-back din_valid=1 produces back-to-back dout_valid=1 with no bubbles.
- Arithmetic:
  - Each operand is extended by one bit: sign-extended if its SIGNED parameter is 1, zero-extended otherwise.
  - The full product width is din0_WIDTH+din1_WIDTH+2, computed as signed. This makes it exact for all mixes.
  - The result is signed if DIN0_SIGNED or DIN1_SIGNED is 1, else unsigned.
- Overflow: dout_ovf=1 when the exact product lies outside the dout_WIDTH range.
  - Signed range: [-2^(W-1), 2^(W-1)-1].
  - Unsigned range: [0, 2^W-1]. A negative product cannot occur for unsigned results.
- SAT_MODE=0: dout = low dout_WIDTH bits of the product; dout_ovf still reports the loss.
- SAT_MODE=1: out-of-range products clamp to the range max or min; dout_ovf=1.
- Reset mid-operation: all in-flight results are discarded. dout_valid=0 on the cycle after reset is sampled and stays 0 until a new pair has traversed the pipe.
- Reset and ce=0 together: reset wins.

Decomposition:
- Shared package multi_radix_hex_pkg holds:
  - function prod_width(a,b) = a+b+2;
  - localparam MUL_MIN_STAGE=2;
  - SAT_MODE encodings MUL_WRAP=0, MUL_SAT=1.
- One natural sub-module: multi_radix_hex_loser_mul_narrow. It is combinational: full product to dout_WIDTH result plus ovf, per SAT_MODE and result signedness.
- The delay stages are a generate loop in the top module.

Test Plan (defaults unless noted):
- Basic latency: din0=-3 (0x7FFD), din1=5, din_valid=1 for one cycle, ce=1 -> dout_valid pulses exactly 4 edges later with dout=0x7FF1 (-15), dout_ovf=0.
- Wrap overflow: din0=16383, din1=16383 (exact 0xFFF8001), SAT_MODE=0 -> dout=0x0001, dout_ovf=1.
- Saturate overflow: same operands with SAT_MODE=1 -> dout=0x3FFF, dout_ovf=1.
- Negative saturate: din0=-16384, din1=2, SAT_MODE=1 -> dout=0x4000 (-16384), dout_ovf=1.
- ce stall: issue 3 back-to-back pairs (1×1, 2×2, 3×3), then hold ce=0 for 5 cycles mid-flight -> outputs frozen during the stall; results 1, 4, 9 appear on consecutive ce=1 cycles; total latency is 4 enabled edges each.
- Reset and parameter sweep:
  - Assert reset for one cycle with 3 results in flight -> dout_valid, dout and dout_ovf are 0 next cycle; no stale result ever emerges.
  - Repeat the ce stall and reset scenarios with NUM_STAGE=2 and NUM_STAGE=8, and with DIN0_SIGNED=DIN1_SIGNED=0 using 0x7FFF×0x3FFF (dout_WIDTH=29 -> 0x1FFF4001, no ovf).
